clb_param: RTL and testbench

CLB_PARAM -- requirements
Module: clb_param

---
 rtl/clb_param_if.sv | 8 +
 rtl/clb_param.sv | 63 ++++++
 tb/tb_clb_param.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/clb_param_if.sv
// clb_param_if: CLB bus bundle (config load cfg_start/cfg_en/cfg_din/cfg_done, slice ctrl ce/sr, LUT in, out, q)
interface clb_param_if #(parameter int LUT_K = 4, parameter int NUM_LUT = 2);
  logic cfg_start, cfg_en, cfg_din, cfg_done, ce, sr;
  logic [NUM_LUT*LUT_K-1:0] in;
  logic [NUM_LUT-1:0] out, q;
  modport master(output cfg_start, cfg_en, cfg_din, ce, sr, in, input cfg_done, out, q);
  modport slave(input cfg_start, cfg_en, cfg_din, ce, sr, in, output cfg_done, out, q);
endinterface

// File: rtl/clb_param.sv
// clb_param: serially configured LUT/flop slices; ports k (clock), rst (sync high), b (clb_param_if.slave bus)
module clb_param #(
  parameter int LUT_K = 4,
  parameter int NUM_LUT = 2
) (
  input logic k,
  input logic rst,
  clb_param_if.slave b
);
  localparam int TTW = 1 << LUT_K;
  localparam int SW = TTW + 3;
  localparam int CFG_W = NUM_LUT * SW;
  localparam int CW = $clog2(CFG_W + 1);
  typedef enum logic [1:0] {UNCONF, LOADING, ACTIVE} state_t;
  state_t state, state_n;
  logic [CFG_W-1:0] cfg, cfg_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [NUM_LUT-1:0] l, q, q_n, out;
  logic active;
  assign active = state == ACTIVE;
  always_comb begin
    state_n = state;
    cfg_n = cfg;
    cnt_n = cnt;
    if (b.cfg_start) begin
      state_n = LOADING;
      cnt_n = '0;
    end else if (state == LOADING && b.cfg_en) begin
      cfg_n = {cfg[CFG_W-2:0], b.cfg_din};
      cnt_n = cnt + 1'b1;
      state_n = cnt_n == CW'(CFG_W) ? ACTIVE : LOADING;
    end
  end
  for (genvar i = 0; i < NUM_LUT; i++) begin : g_slice
    logic [SW-1:0] f;
    logic [TTW-1:0] tt;
    logic [LUT_K-1:0] idx;
    assign f = cfg[i*SW +: SW];
    assign tt = f[TTW-1:0];
    // f[TTW+2]=fbsel, f[TTW+1]=srval, f[TTW]=osel
    assign idx = f[TTW+2] ? {q[i], b.in[i*LUT_K +: LUT_K-1]} : b.in[i*LUT_K +: LUT_K];
    assign l[i] = tt[idx];
    // a start while active clears the flops on the same edge that leaves ACTIVE
    assign q_n[i] = !active || b.cfg_start ? 1'b0 : b.sr ? f[TTW+1] : b.ce ? l[i] : q[i];
    assign out[i] = active && (f[TTW] ? q[i] : l[i]);
  end
  always_ff @(posedge k) begin
    if (rst) begin
      state <= UNCONF;
      cfg <= '0;
      cnt <= '0;
      q <= '0;
    end else begin
      state <= state_n;
      cfg <= cfg_n;
      cnt <= cnt_n;
      q <= q_n;
    end
  end
  assign b.cfg_done = active;
  assign b.out = out;
  assign b.q = q;
endmodule

// File: tb/tb_clb_param.sv
// tb_clb_param: randomized self-checking bench for clb_param against a queue-based reference model
module tb_clb_param;
  localparam int LUT_K = 4, NUM_LUT = 2, TTW = 1 << LUT_K, SW = TTW + 3, CFG_W = NUM_LUT * SW;
  logic k = 0, rst = 1;
  clb_param_if #(.LUT_K(LUT_K), .NUM_LUT(NUM_LUT)) b();
  clb_param #(.LUT_K(LUT_K), .NUM_LUT(NUM_LUT)) dut(.k(k), .rst(rst), .b(b));
  always #5 k = ~k;
  int n_chk = 0, n_pass = 0;
  bit bits[$];
  bit m_load = 0, m_act = 0;
  bit [NUM_LUT-1:0] m_q = '0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic bit cb(int j);
    return bits[CFG_W-1-j];
  endfunction
  function automatic bit m_l(int i);
    int idx = 0;
    for (int j = 0; j < LUT_K; j++) idx += int'(b.in[i*LUT_K+j]) << j;
    if (cb(i*SW+TTW+2)) idx = idx % (TTW/2) + int'(m_q[i]) * (TTW/2);
    return cb(i*SW+idx);
  endfunction
  function automatic logic [NUM_LUT-1:0] m_out();
    logic [NUM_LUT-1:0] o = '0;
    for (int i = 0; i < NUM_LUT; i++) o[i] = m_act ? (cb(i*SW+TTW) ? m_q[i] : m_l(i)) : 1'b0;
    return o;
  endfunction
  task automatic cycle();
    bit nl = m_load, na = m_act;
    bit [NUM_LUT-1:0] nq;
    for (int i = 0; i < NUM_LUT; i++)
      nq[i] = !m_act ? 1'b0 : b.sr ? cb(i*SW+TTW+1) : b.ce ? m_l(i) : m_q[i];
    if (rst) begin
      nl = 0; na = 0; nq = '0; bits.delete();
    end else if (b.cfg_start) begin
      nl = 1; na = 0; nq = '0; bits.delete();
    end else if (m_load && b.cfg_en) begin
      bits.push_back(b.cfg_din);
      if (bits.size() == CFG_W) begin nl = 0; na = 1; end
    end
    @(posedge k);
    #1;
    m_load = nl; m_act = na; m_q = nq;
    chk("cfg_done", b.cfg_done, m_act);
    chk("q", b.q, m_q);
    chk("out", b.out, m_out());
  endtask
  function automatic logic [CFG_W-1:0] mk(input logic [TTW-1:0] t0, input logic [2:0] f0,
                                          input logic [TTW-1:0] t1, input logic [2:0] f1);
    return {f1, t1, f0, t0};
  endfunction
  task automatic load(input logic [CFG_W-1:0] v, input bit stall);
    b.cfg_start = 1; b.cfg_en = 1'($urandom_range(0, 1)); b.cfg_din = 1'($urandom);
    cycle();
    b.cfg_start = 0;
    for (int j = CFG_W - 1; j >= 0; j--) begin
      for (int s = stall ? $urandom_range(0, 2) : 0; s > 0; s--) begin
        b.cfg_en = 0; b.cfg_din = 1'($urandom);
        cycle();
        chk("stall_done", b.cfg_done, 1'b0);
      end
      b.cfg_en = 1; b.cfg_din = v[j];
      cycle();
    end
    b.cfg_en = 0;
  endtask
  initial begin
    logic [CFG_W-1:0] v, basic;
    bit prev;
    b.cfg_start = 0; b.cfg_en = 0; b.cfg_din = 0; b.ce = 0; b.sr = 0; b.in = '0;
    cycle(); cycle();
    rst = 0;
    b.cfg_en = 1; b.cfg_din = 1;
    repeat (3) cycle();
    chk("unconf_cfg", dut.cfg, '0);
    b.cfg_en = 0;
    basic = mk(16'h6996, 3'b000, 16'h8000, 3'b001);
    load(basic, 0);
    chk("basic_done", b.cfg_done, 1'b1);
    chk("basic_cfg", dut.cfg, basic);
    b.ce = 1; b.in = 8'h1F; #1;
    chk("xor_1f", b.out[0], 1'b0);
    cycle();
    b.in = 8'hFF; #1;
    chk("xor_ff", b.out[0], 1'b0);
    cycle();
    chk("and_ff_reg", b.out[1], 1'b1);
    b.in = 8'h01; #1;
    chk("xor_01", b.out[0], 1'b1);
    cycle();
    load(basic, 1);
    chk("stall_cfg", dut.cfg, basic);
    chk("stall_final_done", b.cfg_done, 1'b1);
    b.cfg_start = 1; cycle(); b.cfg_start = 0;
    for (int j = CFG_W - 1; j >= CFG_W - 20; j--) begin b.cfg_en = 1; b.cfg_din = basic[j]; cycle(); end
    b.cfg_en = 0; rst = 1; cycle(); rst = 0;
    chk("abort_cfg", dut.cfg, '0);
    b.cfg_start = 1; cycle(); b.cfg_start = 0;
    repeat (3) cycle();
    chk("abort_done", b.cfg_done, 1'b0);
    chk("abort_out", b.out, '0);
    load(basic, 0);
    chk("reload_done", b.cfg_done, 1'b1);
    load(mk(16'h0000, 3'b011, 16'hFFFF, 3'b000), 0);
    b.in = '0; b.sr = 1; b.ce = 0; cycle();
    chk("sr_set", b.q[0], 1'b1);
    b.ce = 1; cycle();
    chk("sr_wins", b.q[0], 1'b1);
    b.sr = 0; b.ce = 0; cycle();
    chk("hold", b.q[0], 1'b1);
    b.ce = 1; cycle();
    chk("ce_load", b.q[0], 1'b0);
    v = mk(16'h00FF, 3'b101, 16'hFFFF, 3'b000);
    load(v, 0);
    b.in = '0; b.ce = 1; b.sr = 0;
    for (int t = 0; t < 6; t++) begin prev = b.q[0]; cycle(); chk("toggle", b.q[0], !prev); end
    b.cfg_start = 1; b.cfg_en = 1; b.cfg_din = 1; cycle();
    chk("start_no_shift", dut.cfg, v);
    chk("reconf_done", b.cfg_done, 1'b0);
    chk("reconf_q", b.q, '0);
    chk("reconf_out", b.out, '0);
    b.cfg_start = 0; b.cfg_en = 0;
    for (int r = 0; r < 20; r++) begin
      v = {$urandom, $urandom};
      load(v, 1);
      chk("rand_cfg", dut.cfg, v);
      for (int t = 0; t < 40; t++) begin
        b.in = 8'($urandom); b.ce = 1'($urandom); b.sr = ($urandom_range(0, 5) == 0);
        b.cfg_en = 1'($urandom); b.cfg_din = 1'($urandom);
        b.cfg_start = ($urandom_range(0, 60) == 0);
        rst = ($urandom_range(0, 70) == 0);
        cycle();
      end
      b.cfg_start = 0; b.cfg_en = 0; rst = 0; b.sr = 0;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
